readback_selector: RTL and testbench

Registered, parametrised readback multiplexer for the host register interface. Maps a byte address onto version, DAC settings and N_CNT wide event counters; returns one data byte per read strobe with one-cycle latency. Multi-byte counters are read coherently: reading byte 0 snapshots the whole counter, and the following bytes come from the snapshot. Sits between the counter/DAC blocks and the host-side byte interface.

---
 rtl/readback_pkg.sv | 20 ++
 rtl/cnt_snapshot.sv | 113 +++++++++++
 rtl/readback_selector.sv | 129 ++++++++++++
 tb/tb_readback_selector.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/readback_pkg.sv
// Shared constants and types for the host readback path: default address map,
// snapshot FSM encoding and the counter-window helper.
package readback_pkg;

  localparam int DEF_VER_ADDR = 'h00;
  localparam int DEF_DAC_LO   = 'h02;
  localparam int DEF_DAC_HI   = 'h09;
  localparam int DEF_CNT_BASE = 'h26;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } snap_state_t;

  // Last address (inclusive) covered by the counter window.
  function automatic int cnt_end(input int base, input int n_cnt, input int cnt_bytes);
    return base + n_cnt * cnt_bytes - 1;
  endfunction

endpackage

// File: rtl/cnt_snapshot.sv
// Coherent multi-byte counter capture: snapshot register, captured channel and FSM.
// Optional idle timeout out of HELD when SEL_SNAP_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | no snapshot pending; byte>0 reads return live data
// HELD  | snapshot of snap_ch valid; byte>0 reads of snap_ch return snapshot
module cnt_snapshot
  import readback_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int N_CNT     = 22,
  parameter int CNT_BYTES = 4,
  parameter int CH_W      = (N_CNT > 1) ? $clog2(N_CNT) : 1,
  parameter int IDX_W     = (CNT_BYTES > 1) ? $clog2(CNT_BYTES) : 1
`ifdef SEL_SNAP_TIMEOUT_EN
  ,
  parameter int SNAP_TMO  = 1023
`endif
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rd_any,
  input  logic                        cnt_rd,
  input  logic [CH_W-1:0]             rd_ch,
  input  logic [IDX_W-1:0]            rd_byte,
  input  logic [DATA_W*CNT_BYTES-1:0] live_word,
  output logic                        snap_sel,
  output logic [DATA_W-1:0]           snap_byte,
  output logic                        snap_busy
`ifdef SEL_SNAP_TIMEOUT_EN
  ,
  output logic                        snap_tmo
`endif
);

  localparam int CNT_W = DATA_W * CNT_BYTES;
  localparam logic [IDX_W-1:0] LAST_BYTE = IDX_W'(CNT_BYTES - 1);

  snap_state_t     state, state_nxt;
  logic [CNT_W-1:0] snap_reg;
  logic [CH_W-1:0]  snap_ch;
  logic             snap_load;
  logic             own_ch;
  logic             tmo_fire;

  assign snap_load = cnt_rd && (rd_byte == '0);
  assign own_ch    = cnt_rd && (rd_byte != '0) && (rd_ch == snap_ch);

`ifdef SEL_SNAP_TIMEOUT_EN
  // Down-counter reloaded by any read; expiry is the terminal count while HELD.
  localparam logic [9:0] TMO_LOAD = 10'(SNAP_TMO - 1);
  logic [9:0] tmo_cnt;

  assign tmo_fire = (state == HELD) && !rd_any && (tmo_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt  <= '0;
      snap_tmo <= 1'b0;
    end else begin
      snap_tmo <= tmo_fire;
      if (rd_any)
        tmo_cnt <= TMO_LOAD;
      else if ((state == HELD) && (tmo_cnt != '0))
        tmo_cnt <= tmo_cnt - 10'd1;
    end
  end
`else
  assign tmo_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (snap_load && (CNT_BYTES > 1))
          state_nxt = HELD;
      end
      HELD: begin
        if (tmo_fire)
          state_nxt = IDLE;
        else if (own_ch && (rd_byte == LAST_BYTE))
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    snap_busy = (state == HELD);
    snap_sel  = (state == HELD) && own_ch;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_reg <= '0;
      snap_ch  <= '0;
    end else if (snap_load) begin
      snap_reg <= live_word;
      snap_ch  <= rd_ch;
    end
  end

  assign snap_byte = snap_reg[rd_byte*DATA_W +: DATA_W];

endmodule

// File: rtl/readback_selector.sv
// Registered host readback mux: version, DAC and coherent counter bytes, one-cycle latency.
// Define SEL_SNAP_TIMEOUT_EN to add the snapshot idle timeout and the snap_tmo output.
module readback_selector
  import readback_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int N_CNT     = 22,
  parameter int CNT_BYTES = 4,
  parameter int CNT_BASE  = DEF_CNT_BASE,
  parameter int DAC_LO    = DEF_DAC_LO,
  parameter int DAC_HI    = DEF_DAC_HI,
  parameter int VER_ADDR  = DEF_VER_ADDR
`ifdef SEL_SNAP_TIMEOUT_EN
  ,
  parameter int SNAP_TMO  = 1023
`endif
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                rd_req,
  input  logic [ADDR_W-1:0]                   rd_addr,
  input  logic [DATA_W-1:0]                   version,
  input  logic [DATA_W-1:0]                   dac,
  input  logic [N_CNT*DATA_W*CNT_BYTES-1:0]   cnt_flat,
  output logic [DATA_W-1:0]                   rd_data,
  output logic                                rd_valid,
  output logic                                rd_err,
  output logic                                snap_busy
`ifdef SEL_SNAP_TIMEOUT_EN
  ,
  output logic                                snap_tmo
`endif
);

  localparam int CNT_W = DATA_W * CNT_BYTES;
  localparam int CH_W  = (N_CNT > 1) ? $clog2(N_CNT) : 1;
  localparam int IDX_W = (CNT_BYTES > 1) ? $clog2(CNT_BYTES) : 1;
  localparam logic [31:0] A_VER    = 32'(VER_ADDR);
  localparam logic [31:0] A_DAC_LO = 32'(DAC_LO);
  localparam logic [31:0] A_DAC_HI = 32'(DAC_HI);
  localparam logic [31:0] A_CNT_LO = 32'(CNT_BASE);
  localparam logic [31:0] A_CNT_HI = 32'(cnt_end(CNT_BASE, N_CNT, CNT_BYTES));

  logic [31:0]       addr_ext;
  logic [31:0]       offset;
  logic              hit_ver, hit_dac, hit_cnt;
  logic [CH_W-1:0]   rd_ch;
  logic [IDX_W-1:0]  rd_byte;
  logic [CNT_W-1:0]  live_word;
  logic [DATA_W-1:0] live_byte;
  logic [DATA_W-1:0] snap_byte;
  logic              snap_sel;
  logic              cnt_rd;
  logic [DATA_W-1:0] data_nxt;
  logic              err_nxt;

  assign addr_ext = 32'(rd_addr);
  assign offset   = addr_ext - A_CNT_LO;

  // Priority version > DAC > counter in case the windows overlap.
  assign hit_ver = (addr_ext == A_VER);
  assign hit_dac = !hit_ver && (addr_ext >= A_DAC_LO) && (addr_ext <= A_DAC_HI);
  assign hit_cnt = !hit_ver && !hit_dac && (addr_ext >= A_CNT_LO) && (addr_ext <= A_CNT_HI);

  // Force channel/byte to zero off-window so the live select never leaves cnt_flat.
  assign rd_ch   = hit_cnt ? CH_W'(offset / 32'(CNT_BYTES)) : '0;
  assign rd_byte = hit_cnt ? IDX_W'(offset % 32'(CNT_BYTES)) : '0;

  assign live_word = cnt_flat[rd_ch*CNT_W +: CNT_W];
  assign live_byte = live_word[rd_byte*DATA_W +: DATA_W];
  assign cnt_rd    = rd_req && hit_cnt;

  cnt_snapshot #(
    .DATA_W    (DATA_W),
    .N_CNT     (N_CNT),
    .CNT_BYTES (CNT_BYTES),
    .CH_W      (CH_W),
    .IDX_W     (IDX_W)
`ifdef SEL_SNAP_TIMEOUT_EN
    ,
    .SNAP_TMO  (SNAP_TMO)
`endif
  ) u_cnt_snapshot (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_any    (rd_req),
    .cnt_rd    (cnt_rd),
    .rd_ch     (rd_ch),
    .rd_byte   (rd_byte),
    .live_word (live_word),
    .snap_sel  (snap_sel),
    .snap_byte (snap_byte),
    .snap_busy (snap_busy)
`ifdef SEL_SNAP_TIMEOUT_EN
    ,
    .snap_tmo  (snap_tmo)
`endif
  );

  always_comb begin
    data_nxt = '0;
    err_nxt  = 1'b0;
    if (hit_ver)
      data_nxt = version;
    else if (hit_dac)
      data_nxt = dac;
    else if (hit_cnt)
      data_nxt = snap_sel ? snap_byte : live_byte;
    else
      err_nxt = 1'b1;
  end

  // rd_data and rd_err hold between reads; only rd_valid pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) begin
        rd_data <= data_nxt;
        rd_err  <= err_nxt;
      end
    end
  end

endmodule

// File: tb/tb_readback_selector.sv
// Directed bench for readback_selector; the timeout section is built only with
// SEL_SNAP_TIMEOUT_EN defined (SNAP_TMO overridden to 16).
module tb_readback_selector;

  localparam int N_CNT = 22;
  localparam int CNT_W = 32;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   rd_req = 1'b0;
  logic [7:0]             rd_addr = '0;
  logic [7:0]             version = 8'h17;
  logic [7:0]             dac = 8'hA5;
  logic [N_CNT*CNT_W-1:0] cnt_flat = '0;
  logic [7:0]             rd_data;
  logic                   rd_valid;
  logic                   rd_err;
  logic                   snap_busy;
`ifdef SEL_SNAP_TIMEOUT_EN
  logic                   snap_tmo;
`endif

  int n_chk = 0;
  int n_err = 0;

  readback_selector #(
    .N_CNT (N_CNT)
`ifdef SEL_SNAP_TIMEOUT_EN
    ,
    .SNAP_TMO (16)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .version   (version),
    .dac       (dac),
    .cnt_flat  (cnt_flat),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_err    (rd_err),
    .snap_busy (snap_busy)
`ifdef SEL_SNAP_TIMEOUT_EN
    ,
    .snap_tmo  (snap_tmo)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int c, input logic [31:0] v);
    cnt_flat[c*CNT_W +: CNT_W] = v;
  endtask

  // Strobe one read; returns just after the capturing edge so outputs are settled.
  task automatic rd(input logic [7:0] a);
    rd_req  = 1'b1;
    rd_addr = a;
    @(posedge clk);
    #1;
    rd_req = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Read and check data/err/valid in one go.
  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] d, input logic e);
    rd(a);
    chk({tag, ".valid"}, 32'(rd_valid), 32'd1);
    chk({tag, ".data"}, 32'(rd_data), 32'(d));
    chk({tag, ".err"}, 32'(rd_err), 32'(e));
  endtask

  initial begin
    set_ch(0, 32'h11223344);
    set_ch(1, 32'hA1A2A3A4);
    set_ch(2, 32'hB1B2B3B4);
    set_ch(21, 32'h21ABCDEF);
    #12;
    chk("rst.data", 32'(rd_data), 32'd0);
    chk("rst.valid", 32'(rd_valid), 32'd0);
    chk("rst.err", 32'(rd_err), 32'd0);
    chk("rst.busy", 32'(snap_busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: version and DAC
    rd_chk("ver", 8'h00, 8'h17, 1'b0);
    rd_chk("dac05", 8'h05, 8'hA5, 1'b0);
    idle(1);
    chk("valid.drop", 32'(rd_valid), 32'd0);
    chk("data.hold", 32'(rd_data), 32'hA5);
    rd_chk("dac02", 8'h02, 8'hA5, 1'b0);
    rd_chk("dac09", 8'h09, 8'hA5, 1'b0);
    rd_chk("gap01", 8'h01, 8'h00, 1'b1);
    rd_chk("gap0a", 8'h0A, 8'h00, 1'b1);

    // 2: coherent read of channel 0
    rd_chk("c0b0", 8'h26, 8'h44, 1'b0);
    chk("c0.busy", 32'(snap_busy), 32'd1);
    set_ch(0, 32'h55667788);
    rd_chk("c0b1", 8'h27, 8'h33, 1'b0);
    rd_chk("c0b2", 8'h28, 8'h22, 1'b0);
    chk("c0.busy2", 32'(snap_busy), 32'd1);
    rd_chk("c0b3", 8'h29, 8'h11, 1'b0);
    chk("c0.busy_end", 32'(snap_busy), 32'd0);

    // 3: unmapped, then error clears
    rd_chk("unm_f0", 8'hF0, 8'h00, 1'b1);
    rd_chk("after_unm", 8'h00, 8'h17, 1'b0);
    rd_chk("c21b3_live", 8'h7D, 8'h21, 1'b0);
    rd_chk("unm_7e", 8'h7E, 8'h00, 1'b1);

    // 4: foreign channel byte is live, own channel byte from snapshot
    rd_chk("c1b0", 8'h2A, 8'hA4, 1'b0);
    set_ch(1, 32'hC1C2C3C4);
    rd_chk("c2b1_live", 8'h2F, 8'hB3, 1'b0);
    chk("c1.busy", 32'(snap_busy), 32'd1);
    rd_chk("c1b1_snap", 8'h2B, 8'hA3, 1'b0);
    chk("c1.busy2", 32'(snap_busy), 32'd1);
    rd_chk("ver_in_held", 8'h00, 8'h17, 1'b0);
    chk("c1.busy3", 32'(snap_busy), 32'd1);
    rd_chk("c1b3_snap", 8'h2D, 8'hA1, 1'b0);
    chk("c1.busy_end", 32'(snap_busy), 32'd0);

    // 5: reset mid-sequence
    rd_chk("r_c0b0", 8'h26, 8'h88, 1'b0);
    chk("r.busy", 32'(snap_busy), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("r.data", 32'(rd_data), 32'd0);
    chk("r.valid", 32'(rd_valid), 32'd0);
    chk("r.busy0", 32'(snap_busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_ch(0, 32'h99AABBCC);
    @(posedge clk);
    #1;
    rd_chk("r_c0b1_live", 8'h27, 8'hBB, 1'b0);
    chk("r.busy1", 32'(snap_busy), 32'd0);

`ifdef SEL_SNAP_TIMEOUT_EN
    // 6: idle timeout out of HELD
    rd_chk("t_c0b0", 8'h26, 8'hCC, 1'b0);
    set_ch(0, 32'h0102_0304);
    idle(15);
    chk("t.busy15", 32'(snap_busy), 32'd1);
    chk("t.tmo15", 32'(snap_tmo), 32'd0);
    idle(1);
    chk("t.tmo16", 32'(snap_tmo), 32'd1);
    chk("t.busy16", 32'(snap_busy), 32'd0);
    idle(1);
    chk("t.tmo_pulse", 32'(snap_tmo), 32'd0);
    rd_chk("t_c0b1_live", 8'h27, 8'h03, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
